// File: rtl/sr_sched_pkg.sv
// Shared state encoding and sizing helpers for the SR latch bank scheduler.
package sr_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_ACK   = 3'd4
  } state_e;

  // The counter only ever holds (phase length - 1).
  function automatic int cnt_width(input int setup_cycles, input int pulse_cycles);
    int longest;
    longest = (setup_cycles > pulse_cycles) ? setup_cycles : pulse_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

  function automatic int grant_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/sr_latch_bank_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above rrPtr_i, wrapping.
module rr_arbiter
  import sr_sched_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int GW      = grant_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] reqValid_i,
  input  logic [GW-1:0]      rrPtr_i,
  output logic [GW-1:0]      winner_o,
  output logic               anyValid_o
);

  logic [NUM_REQ-1:0] rot;
  logic [GW:0]        offs;
  logic [GW:0]        sum;

  // Rotate so bit 0 is the requester at rrPtr_i; the lowest set bit then wins.
  assign rot        = NUM_REQ'({reqValid_i, reqValid_i} >> rrPtr_i);
  assign anyValid_o = |reqValid_i;

  always_comb begin
    offs = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        offs = (GW+1)'(j);
      end
    end
    sum = {1'b0, rrPtr_i} + offs;
    if (sum >= (GW+1)'(NUM_REQ)) begin
      sum = sum - (GW+1)'(NUM_REQ);
    end
    winner_o = sum[GW-1:0];
  end

endmodule

// File: rtl/sr_latch_bank_scheduler.sv
// Round-robin sequencer sharing one gated SR latch among NUM_REQ requesters.
// Define SR_LATCH_READBACK_CHECK_EN to build the HOLD-cycle readback check driving errorFlag.
module sr_latch_bank_scheduler
  import sr_sched_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  SETUP_CYCLES = 1,
  parameter int  PULSE_CYCLES = 2,
  localparam int GW           = grant_width(NUM_REQ),
  localparam int CW           = cnt_width(SETUP_CYCLES, PULSE_CYCLES)
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic [NUM_REQ-1:0] reqValid,
  input  logic [NUM_REQ-1:0] reqSet,
  output logic [NUM_REQ-1:0] reqAck,
  output logic               latchEnable,
  output logic               latchSet,
  output logic               latchReset,
  input  logic               latchOut,
  output logic               busy,
  output logic [GW-1:0]      grantId,
  output logic               errorFlag
);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      rrPtr_q, rrPtr_d;
  logic [GW-1:0]      winner;
  logic               anyValid;
  logic               opSet_q, opSet_d;
  logic               latchEnable_q, latchEnable_d;
  logic               latchSet_q, latchSet_d;
  logic               latchReset_q, latchReset_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] reqAck_q, reqAck_d;
  logic               driving;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .reqValid_i (reqValid),
    .rrPtr_i    (rrPtr_q),
    .winner_o   (winner),
    .anyValid_o (anyValid)
  );

  // The counter is reloaded with (length - 1) on entry to each timed phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    opSet_d = opSet_q;
    rrPtr_d = rrPtr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (anyValid) begin
          state_d = ST_SETUP;
          cnt_d   = CW'(SETUP_CYCLES - 1);
          grant_d = winner;
          opSet_d = reqSet[winner];
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(PULSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_ACK;
        cnt_d   = '0;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        rrPtr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_comb begin
    driving       = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
    latchSet_d    = driving & opSet_d;
    latchReset_d  = driving & ~opSet_d;
    latchEnable_d = (state_d == ST_PULSE);
    busy_d        = (state_d != ST_IDLE);
    reqAck_d      = (state_d == ST_ACK) ? (NUM_REQ'(1) << grant_d) : '0;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      grant_q       <= '0;
      opSet_q       <= 1'b0;
      rrPtr_q       <= '0;
      latchEnable_q <= 1'b0;
      latchSet_q    <= 1'b0;
      latchReset_q  <= 1'b0;
      busy_q        <= 1'b0;
      reqAck_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      opSet_q       <= opSet_d;
      rrPtr_q       <= rrPtr_d;
      latchEnable_q <= latchEnable_d;
      latchSet_q    <= latchSet_d;
      latchReset_q  <= latchReset_d;
      busy_q        <= busy_d;
      reqAck_q      <= reqAck_d;
    end
  end

  assign latchEnable = latchEnable_q;
  assign latchSet    = latchSet_q;
  assign latchReset  = latchReset_q;
  assign busy        = busy_q;
  assign grantId     = grant_q;
  assign reqAck      = reqAck_q;

`ifdef SR_LATCH_READBACK_CHECK_EN
  logic errorFlag_q, errorFlag_d;

  // Sticky: any HOLD cycle where the latch disagrees with the requested op.
  assign errorFlag_d = errorFlag_q | ((state_q == ST_HOLD) && (latchOut != opSet_q));

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      errorFlag_q <= 1'b0;
    end else begin
      errorFlag_q <= errorFlag_d;
    end
  end

  assign errorFlag = errorFlag_q;
`else
  logic unused_latchOut;
  assign unused_latchOut = latchOut;
  assign errorFlag       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_bank_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_sr_latch_bank_scheduler;

  localparam int N       = 4;
  localparam int S       = 1;
  localparam int P       = 2;
  localparam int HOLD_OF = S + P + 1;
  localparam int ACK_OF  = S + P + 2;
  localparam int TX_LEN  = S + P + 3;
`ifdef SR_LATCH_READBACK_CHECK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         nReset;
  logic [N-1:0] reqValid;
  logic [N-1:0] reqSet;
  logic [N-1:0] reqAck;
  logic         latchEnable, latchSet, latchReset;
  logic         latchOut = 1'b0;
  logic         busy, errorFlag;
  logic [1:0]   grantId;

  sr_latch_bank_scheduler #(
    .NUM_REQ      (N),
    .SETUP_CYCLES (S),
    .PULSE_CYCLES (P)
  ) dut (
    .clock       (clock),
    .nReset      (nReset),
    .reqValid    (reqValid),
    .reqSet      (reqSet),
    .reqAck      (reqAck),
    .latchEnable (latchEnable),
    .latchSet    (latchSet),
    .latchReset  (latchReset),
    .latchOut    (latchOut),
    .busy        (busy),
    .grantId     (grantId),
    .errorFlag   (errorFlag)
  );

  always #5 clock = ~clock;

  // Gated SR latch seen by the scheduler; stuck0 models a latch that will not set.
  logic stuck0 = 1'b0;
  always @(posedge clock) begin
    if (stuck0) latchOut <= 1'b0;
    else if (latchEnable && latchSet) latchOut <= 1'b1;
    else if (latchEnable && latchReset) latchOut <= 1'b0;
  end

  // What the DUT saw at each rising edge.
  logic         smp_rst = 1'b0;
  logic [N-1:0] smp_valid = '0;
  logic [N-1:0] smp_set = '0;
  always @(posedge clock) begin
    smp_rst   <= nReset;
    smp_valid <= reqValid;
    smp_set   <= reqSet;
  end

  // Timeline model: a transaction accepted in idle cycle t0 occupies offsets 1..ACK_OF.
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit have_tx  = 1'b0;
  int t0       = 0;
  int w        = 0;
  bit op       = 1'b0;
  int rr       = 0;
  bit err_exp  = 1'b0;
  int en_count = 0;
  int ack_cyc[$];
  int ack_idx[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle(input bit rnd);
    int           o;
    int           k;
    bit           found;
    bit           drv;
    logic [N-1:0] exp_ack;
    @(negedge clock);
    cyc++;
    if (!smp_rst) begin
      have_tx = 1'b0;
      rr      = 0;
      err_exp = 1'b0;
    end else if ((!have_tx || (cyc - 1 - t0) >= TX_LEN) && smp_valid != '0) begin
      found = 1'b0;
      for (int j = 0; j < N; j++) begin
        k = (rr + j) % N;
        if (!found && smp_valid[2'(k)]) begin
          found = 1'b1;
          w     = k;
        end
      end
      op      = smp_set[2'(w)];
      t0      = cyc - 1;
      have_tx = 1'b1;
    end
    o       = have_tx ? (cyc - t0) : -1;
    drv     = (o >= 1) && (o <= HOLD_OF);
    exp_ack = (o == ACK_OF) ? (N'(1) << w) : '0;
    chk("busy", busy, (o >= 1) && (o <= ACK_OF));
    chk("latchEnable", latchEnable, (o >= S + 1) && (o <= S + P));
    chk("latchSet", latchSet, drv && op);
    chk("latchReset", latchReset, drv && !op);
    chk("set_and_reset", latchSet & latchReset, 0);
    chk("reqAck", reqAck, exp_ack);
    chk("errorFlag", errorFlag, err_exp);
    if ((o >= 1) && (o <= ACK_OF)) chk("grantId", grantId, w);
    if (reqAck != '0) begin
      ack_cyc.push_back(cyc);
      for (int i = 0; i < N; i++) if (reqAck[2'(i)]) ack_idx.push_back(i);
    end
    if (latchEnable) en_count++;
    if (o == HOLD_OF && RB_EN && latchOut !== op) err_exp = 1'b1;
    if (o == ACK_OF) begin
      reqValid = reqValid & ~(N'(1) << w);
      rr       = (w + 1) % N;
    end
    if (rnd) begin
      if ((o >= 1) && (o < ACK_OF) && $urandom_range(15) == 0)
        reqValid = reqValid & ~(N'(1) << w);
      for (int i = 0; i < N; i++)
        if (!reqValid[2'(i)] && $urandom_range(2) == 0) reqValid[2'(i)] = 1'b1;
      reqSet = N'($urandom);
    end
  endtask

  task automatic run_n(input int n, input bit rnd);
    for (int i = 0; i < n; i++) run_cycle(rnd);
  endtask

  initial begin
    int c0;
    bit reached;
    reqValid = '0;
    reqSet   = '0;
    nReset   = 1'b0;
    run_n(3, 1'b0);
    chk("rst_grantId", grantId, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errorFlag", errorFlag, 0);
    nReset = 1'b1;
    run_n(2, 1'b0);

    // Single set request from requester 0.
    ack_cyc.delete(); ack_idx.delete();
    en_count = 0;
    c0       = cyc;
    reqValid = 4'b0001;
    reqSet   = 4'b0001;
    run_n(8, 1'b0);
    chk("t1_ack_count", ack_cyc.size(), 1);
    if (ack_cyc.size() > 0) begin
      chk("t1_ack_latency", ack_cyc[0] - c0, 5);
      chk("t1_ack_idx", ack_idx[0], 0);
    end
    chk("t1_enable_width", en_count, 2);
    chk("t1_latchOut", latchOut, 1);

    // Requester 2 sets, then resets.
    reqValid = 4'b0100; reqSet = 4'b0100;
    run_n(7, 1'b0);
    chk("t3_latchOut_set", latchOut, 1);
    reqValid = 4'b0100; reqSet = 4'b0000;
    run_n(7, 1'b0);
    chk("t3_latchOut_reset", latchOut, 0);

    // Reset in the middle of a pulse abandons the transaction.
    reqValid = 4'b1111;
    reqSet   = 4'b0101;
    reached  = 1'b0;
    for (int i = 0; i < 12 && !reached; i++) begin
      run_cycle(1'b0);
      if (have_tx && (cyc - t0) == S + 1) reached = 1'b1;
    end
    chk("rst_reach_pulse", reached, 1);
    #2 nReset = 1'b0;
    #1;
    chk("arst_latchEnable", latchEnable, 0);
    chk("arst_latchSet", latchSet, 0);
    chk("arst_latchReset", latchReset, 0);
    chk("arst_busy", busy, 0);
    chk("arst_reqAck", reqAck, 0);
    chk("arst_grantId", grantId, 0);
    ack_cyc.delete(); ack_idx.delete();
    run_cycle(1'b0);
    nReset = 1'b1;

    // All four pending after reset: served 0,1,2,3 six cycles apart.
    run_n(27, 1'b0);
    chk("rr_ack_count", ack_cyc.size(), 4);
    for (int i = 0; i < ack_idx.size(); i++) chk("rr_order", ack_idx[i], i);
    for (int i = 1; i < ack_cyc.size(); i++) chk("rr_spacing", ack_cyc[i] - ack_cyc[i-1], 6);
    chk("rr_drained", reqValid, 0);

    // Pointer wrapped to 0: requesters 0 and 3 are served 0 first.
    ack_cyc.delete(); ack_idx.delete();
    reqValid = 4'b1001; reqSet = 4'b0000;
    run_n(14, 1'b0);
    chk("wrap_ack_count", ack_idx.size(), 2);
    if (ack_idx.size() == 2) begin
      chk("wrap_first", ack_idx[0], 0);
      chk("wrap_second", ack_idx[1], 3);
    end

    // Random traffic, then drain.
    run_n(400, 1'b1);
    run_n(40, 1'b0);
    chk("random_drained", reqValid, 0);

    // Latch refuses to set: readback error only when the check is built.
    stuck0 = 1'b1;
    ack_cyc.delete(); ack_idx.delete();
    reqValid = 4'b0001; reqSet = 4'b0001;
    run_n(8, 1'b0);
    chk("rb_ack_count", ack_cyc.size(), 1);
    chk("rb_errorFlag", errorFlag, RB_EN);
    stuck0 = 1'b0;
    run_n(10, 1'b0);
    chk("rb_errorFlag_sticky", errorFlag, RB_EN);
    nReset = 1'b0;
    run_cycle(1'b0);
    nReset = 1'b1;
    run_n(2, 1'b0);
    chk("rb_errorFlag_cleared", errorFlag, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_bank_scheduler.md
# sr_latch_bank_scheduler

Sequencer and round-robin arbiter that shares one gated SR latch (enable/set/reset inputs, out/notout outputs) between several requesters. Each requester asks for the latch to be set or reset. The block grants one request at a time and drives a clean setup/enable-pulse/hold sequence. Set and reset are never asserted together, so the latch never sees its forbidden input state. The block sits between requester logic and the latch datapath.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SETUP_CYCLES, 1, cycles set/reset are stable before the enable pulse (≥1)
- PULSE_CYCLES, 2, width of the latch enable pulse in cycles (≥1)

Ports:
- clock  input  1  single system clock, rising edge
- nReset  input  1  asynchronous, active-low reset
- reqValid  input  NUM_REQ  per-requester request; held high until its reqAck
- reqSet  input  NUM_REQ  per-requester operation: 1 = set latch, 0 = reset latch
- reqAck  output  NUM_REQ  one-cycle completion pulse, one-hot
- latchEnable  output  1  enable input of the latch
- latchSet  output  1  set input of the latch
- latchReset  output  1  reset input of the latch
- latchOut  input  1  latch out, used for readback
- busy  output  1  high in every state except IDLE
- grantId  output  clog2(NUM_REQ)  index of the requester being served; valid while busy
- errorFlag  output  1  sticky readback mismatch

## Operation
- States: IDLE, SETUP, PULSE, HOLD, ACK.
- IDLE: if any reqValid is high, choose a winner:
  - The winner is the first asserted index at or above rrPtr, wrapping modulo NUM_REQ.
  - Capture the winner's index into grantId and its reqSet bit into opSet.
  - Go to SETUP. With no request, stay in IDLE.
- SETUP: latchSet=opSet, latchReset=~opSet, latchEnable=0. Lasts SETUP_CYCLES cycles, then PULSE.
- PULSE: set/reset are held and latchEnable=1. Lasts PULSE_CYCLES cycles, then HOLD.
- HOLD: latchEnable=0 and set/reset are held for 1 cycle, then ACK.
- ACK: reqAck[grantId]=1 for 1 cycle. rrPtr becomes (grantId+1) mod NUM_REQ. Then IDLE.
- Output invariants:
  - latchSet & latchReset is never 1.
  - In IDLE both are 0.
- Requests are captured only in IDLE. Changes to reqValid or reqSet during a transaction have no effect on it.
- If a requester drops reqValid mid-transaction, the transaction still completes and reqAck still pulses.
- If reqValid is still high in the cycle after ACK, that request is a new request.
- An internal cycle counter, sized for max(SETUP_CYCLES, PULSE_CYCLES), is reloaded on every state entry.

## Timing
- All outputs are registered.
- Reset values: latchEnable=0, latchSet=0, latchReset=0, reqAck=0, busy=0, grantId=0, errorFlag=0, rrPtr=0, state IDLE.
- Asserting nReset mid-transaction forces the reset values immediately. The transaction is abandoned with no ack.
- Latency: reqValid is sampled in IDLE at edge k. reqAck is high during cycle k+SETUP_CYCLES+PULSE_CYCLES+2, counting cycle k+1 as the first SETUP cycle. With the defaults, ack is 5 cycles after the sampling edge.
- Back-to-back throughput: one transaction per SETUP_CYCLES+PULSE_CYCLES+3 cycles (IDLE occupies ≥1 cycle). With the defaults this is 6 cycles.
- Simultaneous requests are served in strict round-robin order. No requester waits longer than NUM_REQ−1 other transactions.

## Configuration
- Macro: SR_LATCH_READBACK_CHECK_EN.
- When defined:
  - In the HOLD cycle, latchOut is compared to opSet.
  - On a mismatch, errorFlag is set and stays set until nReset.
  - The transaction still acks.
- When not defined:
  - latchOut is ignored.
  - errorFlag is constant 0.
  - No compare logic is built.

## Structure
- Package sr_sched_pkg holds:
  - the state enum (IDLE, SETUP, PULSE, HOLD, ACK) with a fixed binary encoding;
  - the counter width function;
  - the grant-index width function.
- Sub-module rr_arbiter (parameter NUM_REQ) takes reqValid and rrPtr. It combinationally returns the winner index and an anyValid flag.
- The top level holds the FSM, counter, capture registers and readback check.

## Test plan
- Reset, then a single request reqValid=4'b0001, reqSet=1 → SETUP with latchSet=1 for 1 cycle, latchEnable high for exactly 2 cycles, reqAck=4'b0001 five cycles after sampling, then latchOut=1.
- All four requesters request on the same cycle with rrPtr=0 → acks occur in order 0,1,2,3, 6 cycles apart, and rrPtr wraps back to 0.
- Requester 2 set, then requester 2 reset → latchSet and latchReset are never high together in any cycle, and latchOut ends at 0.
- nReset pulsed low during PULSE → all outputs are 0 in the same cycle, no reqAck, and after release the next grant starts from index 0.
- With SR_LATCH_READBACK_CHECK_EN defined, latchOut forced to 0 during a set → errorFlag=1 after HOLD, reqAck still pulses, and errorFlag holds until reset. Without the macro, errorFlag stays 0.
